// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: request opcodes,
// FSM state encoding and the alignment / classification helpers.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LD_DATA   = 2'd1,
    S_RMW_MERGE = 2'd2,
    S_RMW_WRITE = 2'd3
  } state_e;

  // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary.
  function automatic logic op_aligned(input logic [3:0] op, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    if (op == OP_LW || op == OP_SW)
      ok = (off == 2'b00);
    else if (op == OP_LH || op == OP_LHU || op == OP_SH)
      ok = ~off[0];
    return ok;
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational lane logic for big-endian sub-word access: pulls the
// addressed byte/halfword out of a word (with extension) and merges a
// store lane into a word while keeping every other byte intact.
module byte_lane
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_op,
  input  logic [15:0] i_store_data,
  output logic [31:0] o_extract,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Offset 0 is the most significant lane; extract and merge share the lane select.
  always_comb begin
    w_byte    = i_word[7:0];
    w_half    = i_offset[1] ? i_word[15:0] : i_word[31:16];
    o_extract = i_word;
    o_merge   = i_word;
    case (i_offset)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    case (i_op)
      OP_LB:   o_extract = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_extract = {24'h000000, w_byte};
      OP_LH:   o_extract = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_extract = {16'h0000, w_half};
      default: o_extract = i_word;
    endcase
    if (i_op == OP_SB) begin
      case (i_offset)
        2'd0:    o_merge[31:24] = i_store_data[7:0];
        2'd1:    o_merge[23:16] = i_store_data[7:0];
        2'd2:    o_merge[15:8]  = i_store_data[7:0];
        default: o_merge[7:0]   = i_store_data[7:0];
      endcase
    end else if (i_op == OP_SH) begin
      if (i_offset[1])
        o_merge[15:0] = i_store_data;
      else
        o_merge[31:16] = i_store_data;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only data memory. Loads take
// one extra cycle, sub-word stores are read-modify-write, word stores go
// straight through, and misaligned requests raise an exception pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              misalign_exc,
  output logic [ADDR_W-1:0] dm_address,
  output logic              dm_read,
  output logic              dm_write,
  output logic [DATA_W-1:0] dm_write_data,
  input  logic [DATA_W-1:0] dm_read_data
);

  state_e            r_state;
  state_e            w_next_state;
  logic [3:0]        r_op_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_wbuf;
  logic [DATA_W-1:0] r_load_data;
  logic              r_load_valid;
  logic              r_misalign;

  logic [3:0]        w_op;
  logic              w_aligned;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_stall;
  logic              w_dm_read;
  logic              w_dm_write;
  logic [ADDR_W-1:0] w_dm_address;
  logic [DATA_W-1:0] w_dm_write_data;
  logic [31:0]       w_extract;
  logic [31:0]       w_merge;

  // Undefined opcodes and idle cycles both collapse to NONE.
  assign w_op         = (req_valid && (mem_op <= OP_SB)) ? mem_op : OP_NONE;
  assign w_aligned    = op_aligned(w_op, addr[1:0]);
  assign w_accept     = (r_state == S_IDLE) && (w_op != OP_NONE) && w_aligned;
  assign w_misaligned = (r_state == S_IDLE) && (w_op != OP_NONE) && !w_aligned;

  byte_lane u_byte_lane (
    .i_word       (dm_read_data),
    .i_offset     (r_addr_q[1:0]),
    .i_op         (r_op_q),
    .i_store_data (store_data[15:0]),
    .o_extract    (w_extract),
    .o_merge      (w_merge)
  );

  // Next-state and memory-port decode; later states use only the latched request.
  always_comb begin
    w_next_state    = r_state;
    w_stall         = 1'b0;
    w_dm_read       = 1'b0;
    w_dm_write      = 1'b0;
    w_dm_address    = {2'b00, addr[ADDR_W-1:2]};
    w_dm_write_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op_is_load(w_op)) begin
            w_dm_read    = 1'b1;
            w_stall      = 1'b1;
            w_next_state = S_LD_DATA;
          end else if (w_op == OP_SW) begin
            w_dm_write      = 1'b1;
            w_dm_write_data = store_data;
          end else begin
            w_dm_read    = 1'b1;
            w_stall      = 1'b1;
            w_next_state = S_RMW_MERGE;
          end
        end
      end
      S_LD_DATA: begin
        w_stall      = 1'b1;
        w_dm_address = {2'b00, r_addr_q[ADDR_W-1:2]};
        w_next_state = S_IDLE;
      end
      S_RMW_MERGE: begin
        w_stall      = 1'b1;
        w_dm_address = {2'b00, r_addr_q[ADDR_W-1:2]};
        w_next_state = S_RMW_WRITE;
      end
      S_RMW_WRITE: begin
        w_dm_write      = 1'b1;
        w_dm_write_data = r_wbuf;
        w_dm_address    = {2'b00, r_addr_q[ADDR_W-1:2]};
        w_next_state    = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Reset forces every combinational output low immediately, aborting any write.
  assign stall         = rst_n & w_stall;
  assign dm_read       = rst_n & w_dm_read;
  assign dm_write      = rst_n & w_dm_write;
  assign dm_address    = rst_n ? w_dm_address : '0;
  assign dm_write_data = rst_n ? w_dm_write_data : '0;
  assign load_data     = r_load_data;
  assign load_valid    = r_load_valid;
  assign misalign_exc  = r_misalign;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Capture the accepted operation and address for the following states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q   <= OP_NONE;
      r_addr_q <= '0;
    end else if (w_accept) begin
      r_op_q   <= w_op;
      r_addr_q <= addr;
    end
  end

  // Register the extended load result and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= (r_state == S_LD_DATA);
      if (r_state == S_LD_DATA) r_load_data <= w_extract;
    end
  end

  // Hold the merged word so it can be written in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_wbuf <= '0;
    else if (r_state == S_RMW_MERGE)   r_wbuf <= w_merge;
  end

  // Misalignment exception pulses in the cycle after the offending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_misaligned;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small word memory model
// that reads at posedge and writes at negedge.
module tb_mem_access_unit;

  localparam logic [3:0] LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4, LBU = 4'd5;
  localparam logic [3:0] SW = 4'd6, SH = 4'd7, SB = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_exc;
  logic [31:0] dm_address;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  logic [31:0] mem [0:63];
  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .mem_op        (mem_op),
    .addr          (addr),
    .store_data    (store_data),
    .stall         (stall),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .misalign_exc  (misalign_exc),
    .dm_address    (dm_address),
    .dm_read       (dm_read),
    .dm_write      (dm_write),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears the cycle after dm_read.
  always @(posedge clk) begin
    if (dm_read) dm_read_data <= mem[dm_address[5:0]];
  end

  // Memory model: writes land at the negedge of the write cycle.
  always @(negedge clk) begin
    if (dm_write) mem[dm_address[5:0]] = dm_write_data;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; mem_op = LW; addr = 32'h10; store_data = 32'hFFFFFFFF;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    checks++; if (dm_read !== 1'b0 || dm_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_enables: rd=%b wr=%b want 0/0", dm_read, dm_write); end
    checks++; if (dm_address !== 32'h0 || dm_write_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus: addr=%h wd=%h want 0/0", dm_address, dm_write_data); end
    checks++; if (load_data !== 32'h0 || load_valid !== 1'b0 || misalign_exc !== 1'b0) begin errors++; $display("[TB] FAIL reset_regs: ld=%h lv=%b mx=%b want 0", load_data, load_valid, misalign_exc); end
    step();
    step();
    req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [3:0]  ops  [4] = '{LB, LBU, LH, LHU};
    logic [31:0] adrs [4] = '{32'h10, 32'h10, 32'h12, 32'h12};
    logic [31:0] exps [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFF344, 32'h0000F344};
    mem[4] = 32'h8822F344;
    for (int i = 0; i < 4; i++) begin
      step();
      req_valid = 1'b1; mem_op = ops[i]; addr = adrs[i];
      #1;
      checks++; if (dm_read !== 1'b1 || stall !== 1'b1 || dm_address !== 32'd4) begin errors++; $display("[TB] FAIL load%0d_c0: rd=%b st=%b a=%h want 1/1/4", i, dm_read, stall, dm_address); end
      step();
      #1;
      checks++; if (stall !== 1'b1 || load_valid !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_c1: st=%b lv=%b want 1/0", i, stall, load_valid); end
      step();
      req_valid = 1'b0;
      #1;
      checks++; if (load_valid !== 1'b1 || load_data !== exps[i] || stall !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_c2: lv=%b ld=%h st=%b want 1/%h/0", i, load_valid, load_data, stall, exps[i]); end
      step();
      checks++; if (load_valid !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_pulse: lv=%b want 0", i, load_valid); end
    end
  endtask

  task automatic test_store_word();
    step();
    req_valid = 1'b1; mem_op = SW; addr = 32'h20; store_data = 32'hDEADBEEF;
    #1;
    checks++; if (dm_write !== 1'b1 || dm_address !== 32'd8 || dm_write_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_c0: wr=%b a=%h wd=%h want 1/8/deadbeef", dm_write, dm_address, dm_write_data); end
    checks++; if (stall !== 1'b0 || dm_read !== 1'b0) begin errors++; $display("[TB] FAIL sw_stall: st=%b rd=%b want 0/0", stall, dm_read); end
    step();
    mem_op = LW; addr = 32'h20; store_data = 32'h0;
    #1;
    checks++; if (dm_read !== 1'b1 || dm_write !== 1'b0 || stall !== 1'b1) begin errors++; $display("[TB] FAIL sw_next_lw: rd=%b wr=%b st=%b want 1/0/1", dm_read, dm_write, stall); end
    step();
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (load_valid !== 1'b1 || load_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_readback: lv=%b ld=%h want 1/deadbeef", load_valid, load_data); end
  endtask

  task automatic test_sub_stores();
    mem[4] = 32'h8822F344;
    step();
    req_valid = 1'b1; mem_op = SB; addr = 32'h13; store_data = 32'h000000AB;
    #1;
    checks++; if (dm_read !== 1'b1 || dm_write !== 1'b0 || stall !== 1'b1) begin errors++; $display("[TB] FAIL sb_c0: rd=%b wr=%b st=%b want 1/0/1", dm_read, dm_write, stall); end
    step();
    #1;
    checks++; if (stall !== 1'b1 || dm_write !== 1'b0 || dm_read !== 1'b0) begin errors++; $display("[TB] FAIL sb_c1: st=%b wr=%b rd=%b want 1/0/0", stall, dm_write, dm_read); end
    step();
    #1;
    checks++; if (dm_write !== 1'b1 || dm_write_data !== 32'h8822F3AB || dm_address !== 32'd4 || stall !== 1'b0) begin errors++; $display("[TB] FAIL sb_c2: wr=%b wd=%h a=%h st=%b want 1/8822f3ab/4/0", dm_write, dm_write_data, dm_address, stall); end
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (dm_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL sb_c3: wr=%b st=%b want 0/0", dm_write, stall); end
    step();
    mem[4] = 32'h8822F344;
    req_valid = 1'b1; mem_op = SH; addr = 32'h10; store_data = 32'h00001234;
    step();
    step();
    #1;
    checks++; if (dm_write !== 1'b1 || dm_write_data !== 32'h1234F344) begin errors++; $display("[TB] FAIL sh_c2: wr=%b wd=%h want 1/1234f344", dm_write, dm_write_data); end
    step();
    mem_op = LW; addr = 32'h10; store_data = 32'h0;
    #1;
    checks++; if (dm_read !== 1'b1 || stall !== 1'b1) begin errors++; $display("[TB] FAIL sh_accept_c3: rd=%b st=%b want 1/1", dm_read, stall); end
    step();
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (load_valid !== 1'b1 || load_data !== 32'h1234F344) begin errors++; $display("[TB] FAIL sh_readback: lv=%b ld=%h want 1/1234f344", load_valid, load_data); end
  endtask

  task automatic test_misalign();
    step();
    req_valid = 1'b1; mem_op = LW; addr = 32'h22;
    #1;
    checks++; if (dm_read !== 1'b0 || dm_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_c0: rd=%b wr=%b st=%b want 0/0/0", dm_read, dm_write, stall); end
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (misalign_exc !== 1'b1 || load_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_c1: mx=%b lv=%b want 1/0", misalign_exc, load_valid); end
    step();
    checks++; if (misalign_exc !== 1'b0 || load_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_c2: mx=%b lv=%b want 0/0", misalign_exc, load_valid); end
    req_valid = 1'b1; mem_op = SH; addr = 32'h11; store_data = 32'h5555;
    #1;
    checks++; if (dm_read !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_sh: rd=%b st=%b want 0/0", dm_read, stall); end
    step();
    mem_op = SW; addr = 32'h21;
    #1;
    checks++; if (dm_write !== 1'b0 || misalign_exc !== 1'b1) begin errors++; $display("[TB] FAIL mis_sw: wr=%b mx=%b want 0/1", dm_write, misalign_exc); end
    step();
    mem_op = LB; addr = 32'h11;
    #1;
    checks++; if (dm_read !== 1'b1 || stall !== 1'b1) begin errors++; $display("[TB] FAIL byte_aligned: rd=%b st=%b want 1/1", dm_read, stall); end
    step();
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    mem[4] = 32'h8822F344;
    step();
    req_valid = 1'b1; mem_op = LBU; addr = 32'h10;
    step();
    step();
    mem_op = LB; addr = 32'h11;
    #1;
    checks++; if (load_valid !== 1'b1 || load_data !== 32'h00000088 || dm_read !== 1'b1 || stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_c2: lv=%b ld=%h rd=%b st=%b want 1/88/1/1", load_valid, load_data, dm_read, stall); end
    step();
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (load_valid !== 1'b1 || load_data !== 32'h00000022) begin errors++; $display("[TB] FAIL b2b_second: lv=%b ld=%h want 1/22", load_valid, load_data); end
  endtask

  task automatic test_reset_during_rmw();
    mem[4] = 32'h8822F344;
    step();
    req_valid = 1'b1; mem_op = SB; addr = 32'h13; store_data = 32'h000000AB;
    step();
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || dm_read !== 1'b0 || dm_write !== 1'b0 || dm_address !== 32'h0 || dm_write_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_rmw_outputs: st=%b rd=%b wr=%b a=%h wd=%h want all 0", stall, dm_read, dm_write, dm_address, dm_write_data); end
    checks++; if (load_data !== 32'h0 || load_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rmw_regs: ld=%h lv=%b want 0/0", load_data, load_valid); end
    step();
    step();
    rst_n = 1'b1;
    step();
    req_valid = 1'b1; mem_op = LW; addr = 32'h10;
    step();
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (load_valid !== 1'b1 || load_data !== 32'h8822F344) begin errors++; $display("[TB] FAIL rst_rmw_word: lv=%b ld=%h want 1/8822f344", load_valid, load_data); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    dm_read_data = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_store_word();
    test_sub_stores();
    test_misalign();
    test_back_to_back();
    test_reset_during_rmw();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
